ql_vram_arbiter: RTL and testbench

QL_VRAM_ARBITER -- requirements
Module: ql_vram_arbiter

---
 rtl/ql_mem_pkg.sv | 22 ++
 rtl/ql_vram_arbiter_if.sv | 59 +++++
 rtl/ql_slot_timer.sv | 33 +++
 rtl/ql_vram_arbiter.sv | 156 +++++++++++++++
 tb/tb_ql_vram_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ql_mem_pkg.sv
// Shared video-RAM definitions: the slot owner encoding, the slot phase points and the bus widths.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ql_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_MDV  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    // Slot phases, counted in slot_cnt values.
    localparam int ISSUE_START = 1;  // first cycle with mem_rd/mem_we high
    localparam int ISSUE_END   = 4;  // last cycle with mem_rd/mem_we high
    localparam int VIDEO_END   = 3;  // last cycle with video_cycle high

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

endpackage

// File: rtl/ql_vram_arbiter_if.sv
// Requester and memory-side signals of the video RAM arbiter.
// Latency: wires only.
// Backpressure: requests are level-held until the matching one-cycle ack.
// Ports: vid_*, mdv_*, cpu_* request/ack groups; mem_* RAM bus; rdata; video_cycle.
interface ql_vram_arbiter_if;
    import ql_mem_pkg::*;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;

    logic              mdv_men;
    logic              mdv_req;
    logic              mdv_we;
    logic [ADDR_W-1:0] mdv_addr;
    logic [DATA_W-1:0] mdv_wdata;
    logic              mdv_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [BE_W-1:0]   cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              video_cycle;

    // Arbiter side.
    modport slave (
        input  vid_req, vid_addr,
        input  mdv_men, mdv_req, mdv_we, mdv_addr, mdv_wdata,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vid_ack, mdv_ack, cpu_ack, rdata,
        output mem_addr, mem_rd, mem_we, mem_be, mem_wdata,
        output video_cycle
    );

    // Requester / memory-model side.
    modport master (
        output vid_req, vid_addr,
        output mdv_men, mdv_req, mdv_we, mdv_addr, mdv_wdata,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vid_ack, mdv_ack, cpu_ack, rdata,
        input  mem_addr, mem_rd, mem_we, mem_be, mem_wdata,
        input  video_cycle
    );

endinterface

// File: rtl/ql_slot_timer.sv
// Free-running memory slot counter with a registered video_cycle phase flag.
// Latency: slot_cnt and video_cycle are registered; slot_nxt is the combinational next count.
// Backpressure: none, the counter never stalls.
// Ports: clk_video, reset; slot_cnt, slot_nxt, video_cycle outputs.
module ql_slot_timer
    import ql_mem_pkg::*;
#(
    parameter int SLOT_LEN = 8,
    parameter int CW       = $clog2(SLOT_LEN)
) (
    input  logic          clk_video,
    input  logic          reset,
    output logic [CW-1:0] slot_cnt,
    output logic [CW-1:0] slot_nxt,
    output logic          video_cycle
);

    always_comb begin
        slot_nxt = (slot_cnt == CW'(SLOT_LEN - 1)) ? '0 : slot_cnt + CW'(1);
    end

    // video_cycle is computed from the next count so the flag lines up with slot_cnt.
    always_ff @(posedge clk_video) begin
        if (reset) begin
            slot_cnt    <= '0;
            video_cycle <= 1'b1;
        end else begin
            slot_cnt    <= slot_nxt;
            video_cycle <= (slot_nxt <= CW'(VIDEO_END));
        end
    end

endmodule

// File: rtl/ql_vram_arbiter.sv
// Time-slot arbiter sharing QL video RAM between video fetch, microdrive (mdv) and CPU.
// Latency: request sampled at slot_cnt 0, ack and rdata at slot_cnt CAP_CYC+1 (CAP_CYC+1 cycles).
// Backpressure: requests are level-held until ack; a losing requester simply waits for a later slot.
// Ports: clk_video, reset; bus (ql_vram_arbiter_if.slave) carrying requests, acks, rdata, RAM bus, video_cycle.
module ql_vram_arbiter
    import ql_mem_pkg::*;
#(
    parameter int SLOT_LEN   = 8,
    parameter int CAP_CYC    = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk_video,
    input  logic             reset,
    ql_vram_arbiter_if.slave bus
);

    localparam int CW = $clog2(SLOT_LEN);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]     slot_cnt;
    logic [CW-1:0]     slot_nxt;

    owner_e            owner_q;
    owner_e            grant;
    logic              wr_q;
    logic              last_cpu_q;
    logic [SW-1:0]     starve_q;

    logic              sample;
    logic              mdv_ok;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [BE_W-1:0]   grant_be;
    logic [DATA_W-1:0] grant_wdata;
    logic [SW-1:0]     starve_nxt;
    logic              last_cpu_nxt;
    logic              owner_act;
    logic              wr_cur;
    logic              issue_nxt;
    logic              capture;

    ql_slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .CW       (CW)
    ) u_timer (
        .clk_video   (clk_video),
        .reset       (reset),
        .slot_cnt    (slot_cnt),
        .slot_nxt    (slot_nxt),
        .video_cycle (bus.video_cycle)
    );

    // Grant decision, only consumed when slot_cnt is 0.
    always_comb begin
        sample      = (slot_cnt == '0);
        mdv_ok      = bus.mdv_men && bus.mdv_req;
        grant       = OWN_NONE;
        grant_we    = 1'b0;
        grant_addr  = bus.mem_addr;
        grant_be    = bus.mem_be;
        grant_wdata = bus.mem_wdata;

        if (bus.vid_req) begin
            grant = OWN_VID;
        end else if (mdv_ok && bus.cpu_req) begin
            // Alternate between mdv and CPU unless the CPU has lost too many slots in a row.
            if (starve_q >= SW'(STARVE_MAX) || !last_cpu_q) begin
                grant = OWN_CPU;
            end else begin
                grant = OWN_MDV;
            end
        end else if (mdv_ok) begin
            grant = OWN_MDV;
        end else if (bus.cpu_req) begin
            grant = OWN_CPU;
        end

        case (grant)
            OWN_VID: begin
                grant_addr = bus.vid_addr;
                grant_be   = 2'b11;
            end
            OWN_MDV: begin
                grant_we    = bus.mdv_we;
                grant_addr  = bus.mdv_addr;
                grant_be    = 2'b11;
                grant_wdata = bus.mdv_wdata;
            end
            OWN_CPU: begin
                grant_we    = bus.cpu_we;
                grant_addr  = bus.cpu_addr;
                grant_be    = bus.cpu_be;
                grant_wdata = bus.cpu_wdata;
            end
            default: ;
        endcase

        if (!bus.cpu_req || grant == OWN_CPU) begin
            starve_nxt = '0;
        end else if (starve_q < SW'(STARVE_MAX)) begin
            starve_nxt = starve_q + SW'(1);
        end else begin
            starve_nxt = starve_q;
        end

        last_cpu_nxt = last_cpu_q;
        if (grant == OWN_CPU) begin
            last_cpu_nxt = 1'b1;
        end else if (grant == OWN_MDV) begin
            last_cpu_nxt = 1'b0;
        end

        // In the sampling cycle the owner register is still the old slot's; use the fresh grant.
        owner_act = sample ? (grant != OWN_NONE) : (owner_q != OWN_NONE);
        wr_cur    = sample ? grant_we : wr_q;
        issue_nxt = (slot_nxt >= CW'(ISSUE_START)) && (slot_nxt <= CW'(ISSUE_END));
        capture   = (slot_cnt == CW'(CAP_CYC)) && (owner_q != OWN_NONE);
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            wr_q          <= 1'b0;
            last_cpu_q    <= 1'b1;
            starve_q      <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rdata     <= '0;
            bus.vid_ack   <= 1'b0;
            bus.mdv_ack   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
        end else begin
            if (sample) begin
                owner_q       <= grant;
                wr_q          <= grant_we;
                starve_q      <= starve_nxt;
                last_cpu_q    <= last_cpu_nxt;
                bus.mem_addr  <= grant_addr;
                bus.mem_be    <= grant_be;
                bus.mem_wdata <= grant_wdata;
            end
            bus.mem_rd <= owner_act && !wr_cur && issue_nxt;
            bus.mem_we <= owner_act &&  wr_cur && issue_nxt;
            if (capture && !wr_q) begin
                bus.rdata <= bus.mem_rdata;
            end
            bus.vid_ack <= capture && (owner_q == OWN_VID);
            bus.mdv_ack <= capture && (owner_q == OWN_MDV);
            bus.cpu_ack <= capture && (owner_q == OWN_CPU);
        end
    end

endmodule

// File: tb/tb_ql_vram_arbiter.sv
// Directed bench for ql_vram_arbiter with hand-computed per-slot waveforms.
// Latency: each observed slot spans 8 cycles from the sampling edge.
// Backpressure: requests are held across whole slots and dropped just before the next sample.
module tb_ql_vram_arbiter;
    import ql_mem_pkg::*;

    logic clk_video = 1'b0;
    logic reset     = 1'b1;
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   tb_cnt    = 0;

    // One observed slot: bit b of each mask is the signal while slot_cnt == b.
    typedef struct {
        logic [7:0]  rd;
        logic [7:0]  we;
        logic [7:0]  va;
        logic [7:0]  ma;
        logic [7:0]  ca;
        logic [7:0]  vc;
        logic [18:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] rdat;
        logic        stable;
    } slot_t;

    ql_vram_arbiter_if bus();

    ql_vram_arbiter #(
        .SLOT_LEN   (8),
        .CAP_CYC    (5),
        .STARVE_MAX (3)
    ) dut (
        .clk_video (clk_video),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_video = ~clk_video;

    // Bench's own slot position, independent of the design.
    always @(posedge clk_video) tb_cnt <= reset ? 0 : ((tb_cnt == 7) ? 0 : tb_cnt + 1);

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Starts at a negedge with tb_cnt == 0 (inputs already set), ends at the next such negedge.
    task automatic watch_slot(input int drop_men_at, output slot_t s);
        int b;
        s.rd = '0; s.we = '0; s.va = '0; s.ma = '0; s.ca = '0; s.vc = '0;
        s.addr = '0; s.be = '0; s.wd = '0; s.rdat = '0; s.stable = 1'b1;
        n_vec++;
        if (tb_cnt != 0) begin
            n_bad++;
            $display("FAIL slot_align got %0d want 0", tb_cnt);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_video);
            b = i % 8;
            s.rd[b] = bus.mem_rd;
            s.we[b] = bus.mem_we;
            s.va[b] = bus.vid_ack;
            s.ma[b] = bus.mdv_ack;
            s.ca[b] = bus.cpu_ack;
            s.vc[b] = bus.video_cycle;
            if (i == 1) begin
                s.addr = bus.mem_addr;
                s.be   = bus.mem_be;
                s.wd   = bus.mem_wdata;
            end else if (i <= 4) begin
                if (bus.mem_addr !== s.addr || bus.mem_be !== s.be || bus.mem_wdata !== s.wd)
                    s.stable = 1'b0;
            end
            if (i == 6) s.rdat = bus.rdata;
            if (i == drop_men_at) bus.mdv_men = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.mdv_men = 0; bus.mdv_req = 0; bus.mdv_we = 0; bus.mdv_addr = '0; bus.mdv_wdata = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_be = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk_video);
        n_vec++; if ({bus.mem_rd, bus.mem_we} !== 2'b00) begin n_bad++; $display("FAIL rst_rdwe got %b want 00", {bus.mem_rd, bus.mem_we}); end
        n_vec++; if (bus.mem_be !== 2'b00) begin n_bad++; $display("FAIL rst_be got %b want 00", bus.mem_be); end
        n_vec++; if (bus.mem_addr !== 19'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", bus.mem_wdata); end
        n_vec++; if (bus.rdata !== 16'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        n_vec++; if ({bus.vid_ack, bus.mdv_ack, bus.cpu_ack} !== 3'b000) begin n_bad++; $display("FAIL rst_acks got %b want 000", {bus.vid_ack, bus.mdv_ack, bus.cpu_ack}); end
        n_vec++; if (bus.video_cycle !== 1'b1) begin n_bad++; $display("FAIL rst_video_cycle got %b want 1", bus.video_cycle); end
        reset = 1'b0;
    endtask

    task automatic test_vid_read();
        slot_t s;
        bus.vid_req = 1; bus.vid_addr = 19'h10000; bus.mem_rdata = 16'hA55A;
        watch_slot(-1, s);
        bus.vid_req = 0;
        n_vec++; if (s.rd !== 8'h1E) begin n_bad++; $display("FAIL vid_rd_mask got %h want 1e", s.rd); end
        n_vec++; if (s.we !== 8'h00) begin n_bad++; $display("FAIL vid_we_mask got %h want 00", s.we); end
        n_vec++; if (s.va !== 8'h40) begin n_bad++; $display("FAIL vid_ack_mask got %h want 40", s.va); end
        n_vec++; if ((s.ma | s.ca) !== 8'h00) begin n_bad++; $display("FAIL vid_other_acks got %h want 00", s.ma | s.ca); end
        n_vec++; if (s.rdat !== 16'hA55A) begin n_bad++; $display("FAIL vid_rdata got %h want a55a", s.rdat); end
        n_vec++; if (s.addr !== 19'h10000) begin n_bad++; $display("FAIL vid_addr got %h want 10000", s.addr); end
        n_vec++; if (s.be !== 2'b11) begin n_bad++; $display("FAIL vid_be got %b want 11", s.be); end
        n_vec++; if (s.stable !== 1'b1) begin n_bad++; $display("FAIL vid_bus_stable got %b want 1", s.stable); end
        n_vec++; if (s.vc !== 8'h0F) begin n_bad++; $display("FAIL video_cycle_mask got %h want 0f", s.vc); end
    endtask

    task automatic test_cpu_write();
        slot_t s;
        bus.mem_rdata = 16'h1234;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_be = 2'b01; bus.cpu_addr = 19'h00123; bus.cpu_wdata = 16'h00FF;
        watch_slot(-1, s);
        bus.cpu_req = 0; bus.cpu_we = 0;
        n_vec++; if (s.we !== 8'h1E) begin n_bad++; $display("FAIL cpuw_we_mask got %h want 1e", s.we); end
        n_vec++; if (s.rd !== 8'h00) begin n_bad++; $display("FAIL cpuw_rd_mask got %h want 00", s.rd); end
        n_vec++; if (s.ca !== 8'h40) begin n_bad++; $display("FAIL cpuw_ack_mask got %h want 40", s.ca); end
        n_vec++; if ((s.va | s.ma) !== 8'h00) begin n_bad++; $display("FAIL cpuw_other_acks got %h want 00", s.va | s.ma); end
        n_vec++; if (s.rdat !== 16'hA55A) begin n_bad++; $display("FAIL cpuw_rdata_hold got %h want a55a", s.rdat); end
        n_vec++; if (s.be !== 2'b01) begin n_bad++; $display("FAIL cpuw_be got %b want 01", s.be); end
        n_vec++; if (s.wd !== 16'h00FF) begin n_bad++; $display("FAIL cpuw_wdata got %h want 00ff", s.wd); end
        n_vec++; if (s.addr !== 19'h00123) begin n_bad++; $display("FAIL cpuw_addr got %h want 00123", s.addr); end
        n_vec++; if (s.stable !== 1'b1) begin n_bad++; $display("FAIL cpuw_bus_stable got %b want 1", s.stable); end
    endtask

    task automatic test_alternate();
        slot_t s;
        logic  mdv_turn;
        bus.mem_rdata = 16'h0F0F;
        bus.mdv_men = 1; bus.mdv_req = 1; bus.mdv_we = 0; bus.mdv_addr = 19'h00200;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_be = 2'b11; bus.cpu_addr = 19'h00300;
        for (int k = 0; k < 4; k++) begin
            watch_slot(-1, s);
            mdv_turn = (k % 2 == 0);
            n_vec++; if (s.ma !== (mdv_turn ? 8'h40 : 8'h00)) begin n_bad++; $display("FAIL alt_mdv_ack slot %0d got %h want %h", k, s.ma, mdv_turn ? 8'h40 : 8'h00); end
            n_vec++; if (s.ca !== (mdv_turn ? 8'h00 : 8'h40)) begin n_bad++; $display("FAIL alt_cpu_ack slot %0d got %h want %h", k, s.ca, mdv_turn ? 8'h00 : 8'h40); end
            n_vec++; if (s.addr !== (mdv_turn ? 19'h00200 : 19'h00300)) begin n_bad++; $display("FAIL alt_addr slot %0d got %h", k, s.addr); end
        end
        bus.mdv_req = 0; bus.cpu_req = 0;
    endtask

    task automatic test_vid_priority();
        slot_t s;
        bus.vid_req = 1; bus.vid_addr = 19'h00010;
        bus.mdv_men = 1; bus.mdv_req = 1; bus.cpu_req = 1;
        for (int k = 0; k < 8; k++) begin
            watch_slot(-1, s);
            n_vec++; if (s.va !== 8'h40) begin n_bad++; $display("FAIL prio_vid_ack slot %0d got %h want 40", k, s.va); end
            n_vec++; if ((s.ma | s.ca) !== 8'h00) begin n_bad++; $display("FAIL prio_other_acks slot %0d got %h want 00", k, s.ma | s.ca); end
        end
        // Starved CPU must now beat mdv even though the alternation flag favours mdv.
        bus.vid_req = 0;
        watch_slot(-1, s);
        n_vec++; if (s.ca !== 8'h40) begin n_bad++; $display("FAIL starve_cpu_ack got %h want 40", s.ca); end
        n_vec++; if (s.ma !== 8'h00) begin n_bad++; $display("FAIL starve_mdv_ack got %h want 00", s.ma); end
        watch_slot(-1, s);
        n_vec++; if (s.ma !== 8'h40) begin n_bad++; $display("FAIL post_starve_mdv_ack got %h want 40", s.ma); end
        bus.mdv_req = 0; bus.cpu_req = 0;
    endtask

    task automatic test_mdv_window();
        slot_t s;
        bus.mdv_men = 0; bus.mdv_req = 1; bus.mdv_we = 1; bus.mdv_addr = 19'h7FFFF; bus.mdv_wdata = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            watch_slot(-1, s);
            n_vec++; if ((s.rd | s.we) !== 8'h00) begin n_bad++; $display("FAIL men_off_bus slot %0d got %h want 00", k, s.rd | s.we); end
            n_vec++; if ((s.va | s.ma | s.ca) !== 8'h00) begin n_bad++; $display("FAIL men_off_acks slot %0d got %h want 00", k, s.va | s.ma | s.ca); end
        end
        // Window opens, then closes at slot_cnt 2 of the granted slot.
        bus.mdv_men = 1;
        watch_slot(2, s);
        bus.mdv_req = 0; bus.mdv_we = 0;
        n_vec++; if (s.we !== 8'h1E) begin n_bad++; $display("FAIL mdv_we_mask got %h want 1e", s.we); end
        n_vec++; if (s.ma !== 8'h40) begin n_bad++; $display("FAIL mdv_ack_mask got %h want 40", s.ma); end
        n_vec++; if (s.addr !== 19'h7FFFF) begin n_bad++; $display("FAIL mdv_addr got %h want 7ffff", s.addr); end
        n_vec++; if (s.wd !== 16'hBEEF) begin n_bad++; $display("FAIL mdv_wdata got %h want beef", s.wd); end
        n_vec++; if (s.be !== 2'b11) begin n_bad++; $display("FAIL mdv_be got %b want 11", s.be); end
    endtask

    task automatic test_reset_mid();
        slot_t s;
        bus.mem_rdata = 16'h5AA5;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_be = 2'b10; bus.cpu_addr = 19'h00055;
        repeat (3) @(negedge clk_video);
        n_vec++; if (bus.mem_rd !== 1'b1) begin n_bad++; $display("FAIL midrst_rd_before got %b want 1", bus.mem_rd); end
        reset = 1'b1;
        @(negedge clk_video);
        reset = 1'b0;
        n_vec++; if (bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL midrst_rd_after got %b want 0", bus.mem_rd); end
        n_vec++; if (bus.cpu_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_ack got %b want 0", bus.cpu_ack); end
        n_vec++; if (bus.rdata !== 16'h0) begin n_bad++; $display("FAIL midrst_rdata got %h want 0", bus.rdata); end
        watch_slot(-1, s);
        bus.cpu_req = 0;
        n_vec++; if (s.rd !== 8'h1E) begin n_bad++; $display("FAIL regrant_rd_mask got %h want 1e", s.rd); end
        n_vec++; if (s.ca !== 8'h40) begin n_bad++; $display("FAIL regrant_ack_mask got %h want 40", s.ca); end
        n_vec++; if (s.rdat !== 16'h5AA5) begin n_bad++; $display("FAIL regrant_rdata got %h want 5aa5", s.rdat); end
        n_vec++; if (s.be !== 2'b10) begin n_bad++; $display("FAIL regrant_be got %b want 10", s.be); end
    endtask

    initial begin
        test_reset();
        test_vid_read();
        test_cpu_write();
        test_alternate();
        test_vid_priority();
        test_mdv_window();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
